// File: rtl/fft_io_pkg.sv
// Shared types and defaults for the image file port sequencer.
//   seq_state_t   : sequencer FSM state encoding
//   DATA_W_DEF    : default sample / port data width
//   ADDR_W_DEF    : default port address width
//   frame_len_ok  : legal frame length is 1 .. 2**addr_w
package fft_io_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        WR_OPEN,
        WR_DATA,
        WR_CLOSE,
        RD_REQ,
        RD_CAP,
        RD_HOLD,
        FIN
    } seq_state_t;

    function automatic bit frame_len_ok(input int len, input int addr_w);
        return (len >= 1) && (len <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/image_frame_sequencer_if.sv
// Image file port bundle.
//   start_write  : port open strobe
//   end_write    : port close strobe
//   write_enable : write strobe, qualifies address/input_data
//   read_enable  : read strobe, qualifies address
//   address      : port address
//   input_data   : data towards the image file
//   output_data  : data from the image file, valid the cycle after read_enable
// master = sequencer side, slave = image file / memory model side.
interface image_frame_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              start_write;
    logic              end_write;
    logic              write_enable;
    logic              read_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] input_data;
    logic [DATA_W-1:0] output_data;

    modport master (
        output start_write, end_write, write_enable, read_enable,
        output address, input_data,
        input  output_data
    );

    modport slave (
        input  start_write, end_write, write_enable, read_enable,
        input  address, input_data,
        output output_data
    );
endinterface

// File: rtl/frame_counter.sv
// Sample counter for one frame, ADDR_W+1 bits wide so a full 2**ADDR_W
// frame terminates without wrapping.
//   clk, n_rst : clock, synchronous active-low reset
//   clr        : clear count to 0 (wins over en)
//   en         : increment count
//   addr       : current count, truncated to an address
//   addr_nxt   : count+1, truncated to an address
//   tc_next    : count+1 == FRAME_LEN, i.e. the next increment ends the frame
module frame_counter
    import fft_io_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int FRAME_LEN = 1 << ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic              tc_next
);

    localparam logic [ADDR_W:0] TERM = (ADDR_W+1)'(FRAME_LEN);

    logic [ADDR_W:0] count;
    logic [ADDR_W:0] count_inc;

    assign count_inc = count + {{ADDR_W{1'b0}}, 1'b1};
    assign addr      = count[ADDR_W-1:0];
    assign addr_nxt  = count_inc[ADDR_W-1:0];
    assign tc_next   = (count_inc == TERM);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/image_frame_sequencer.sv
// Initiator for the image file port: frames FRAME_LEN samples from the
// write stream into the port, or fetches FRAME_LEN samples by address and
// presents them on the read stream.
//   clk, n_rst              : clock, synchronous active-low reset
//   wr_start / rd_start     : 1-cycle frame start pulses (write wins)
//   s_data/s_valid/s_ready  : write stream in (s_ready combinational)
//   m_data/m_valid/m_ready  : read stream out
//   fm                      : image file port (master side)
//   busy                    : frame in progress
//   done                    : 1-cycle end-of-frame pulse
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for wr_start / rd_start
// WR_OPEN  | port open strobe, count cleared
// WR_DATA  | accepting samples, one write strobe per accept
// WR_CLOSE | last write strobe on the port; close strobe next
// RD_REQ   | read strobe on the port at address count
// RD_CAP   | port data valid, captured into m_data
// RD_HOLD  | m_valid held until m_ready
// FIN      | frame complete; done follows
module image_frame_sequencer
    import fft_io_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int FRAME_LEN = 1 << ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   wr_start,
    input  logic                   rd_start,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    image_frame_sequencer_if.master fm,
    output logic                   busy,
    output logic                   done
);

    if (!frame_len_ok(FRAME_LEN, ADDR_W)) begin : g_bad_frame_len
        $error("image_frame_sequencer: FRAME_LEN outside 1..2**ADDR_W");
    end

    seq_state_t        state, state_next;
    logic              cnt_clr, cnt_en, tc_next;
    logic [ADDR_W-1:0] cnt_addr, cnt_addr_nxt;
    logic              hs_in, hs_out;

    frame_counter #(
        .ADDR_W    (ADDR_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .addr     (cnt_addr),
        .addr_nxt (cnt_addr_nxt),
        .tc_next  (tc_next)
    );

    assign s_ready = (state == WR_DATA);
    assign hs_in   = s_valid && (state == WR_DATA);
    assign hs_out  = m_valid && m_ready && (state == RD_HOLD);

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (wr_start) begin
                    state_next = WR_OPEN;
                end else if (rd_start) begin
                    state_next = RD_REQ;
                    cnt_clr    = 1'b1;
                end
            end
            WR_OPEN: begin
                cnt_clr    = 1'b1;
                state_next = WR_DATA;
            end
            WR_DATA: begin
                if (hs_in) begin
                    cnt_en = 1'b1;
                    if (tc_next) state_next = WR_CLOSE;
                end
            end
            WR_CLOSE: state_next = FIN;
            RD_REQ:   state_next = RD_CAP;
            RD_CAP:   state_next = RD_HOLD;
            RD_HOLD: begin
                if (hs_out) begin
                    cnt_en     = 1'b1;
                    state_next = tc_next ? FIN : RD_REQ;
                end
            end
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // The open and read strobes are registered from state_next so they line
    // up with WR_OPEN / RD_REQ; this puts the port's read data in RD_CAP where
    // it is captured. The close strobe follows the last write strobe by one
    // cycle, so it is registered from the current state instead.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            m_data          <= '0;
            m_valid         <= 1'b0;
            fm.start_write  <= 1'b0;
            fm.end_write    <= 1'b0;
            fm.write_enable <= 1'b0;
            fm.read_enable  <= 1'b0;
            fm.address      <= '0;
            fm.input_data   <= '0;
        end else begin
            state           <= state_next;
            busy            <= (state != IDLE);
            done            <= (state == FIN);
            fm.start_write  <= (state_next == WR_OPEN);
            fm.end_write    <= (state == WR_CLOSE);
            fm.write_enable <= hs_in;
            fm.read_enable  <= (state_next == RD_REQ);
            if (hs_in) begin
                fm.address    <= cnt_addr;
                fm.input_data <= s_data;
            end else if (state_next == RD_REQ) begin
                // from IDLE the counter is being cleared this edge
                fm.address <= (state == IDLE) ? '0 : cnt_addr_nxt;
            end
            if (state == RD_CAP) begin
                m_data  <= fm.output_data;
                m_valid <= 1'b1;
            end else if (hs_out) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
